// File: rtl/cobs_frame_encoder.sv
// -----------------------------------------------------------------------------
// cobs_frame_encoder
//
// Multi-level COBS frame encoder for the interleaved trace path. Each priority
// level owns an independent run buffer, run count and "frame open" flag, so a
// higher level can open, fill and close its own frame while a lower level's
// frame is still open. Frames can be prefixed with a little-endian timestamp
// captured from the timer input when the frame opens. Complete COBS runs
// (code byte + data bytes) and the closing run + 0x00 delimiter are emitted
// atomically, so out_level never changes inside a run.
//
// Ports:
//   clk_i      clock
//   reset_i    synchronous active-high reset
//   in_valid   input byte offered
//   in_ready   input byte accepted when in_valid && in_ready (IDLE only)
//   in_level   frame context of the input byte
//   in_data    payload byte
//   in_last    byte closes the frame of in_level
//   timer      free-running timestamp, captured when a frame opens
//   out_valid  encoded byte valid
//   out_ready  downstream accepts the byte
//   out_data   encoded byte
//   out_level  level owning out_data
//   out_last   high with the 0x00 frame delimiter
// -----------------------------------------------------------------------------
module cobs_frame_encoder #(
  parameter int NumLevels  = 4,
  parameter int MaxRun     = 7,
  parameter int TsBytes    = 4,
  parameter int TimerWidth = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(NumLevels)-1:0] in_level,
  input  logic [7:0]                   in_data,
  input  logic                         in_last,
  input  logic [TimerWidth-1:0]        timer,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic [$clog2(NumLevels)-1:0] out_level,
  output logic                         out_last
);

  localparam int LevelW = $clog2(NumLevels);
  localparam int CntW   = $clog2(MaxRun + 1);
  localparam int IdxW   = (MaxRun > 1) ? $clog2(MaxRun) : 1;
  localparam int TsW    = (TsBytes > 0) ? 8 * TsBytes : 8;
  localparam int TsCntW = $clog2(TsBytes + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TS,
    S_APPEND,
    S_CODE,
    S_DATA,
    S_DELIM
  } state_t;

  state_t state, state_d;
  // State to resume once the current flush (CODE/DATA) has drained.
  state_t ret_state, ret_d;

  // Pending input byte, held until it has been fully processed.
  logic [LevelW-1:0] pend_level;
  logic [7:0]        pend_data;
  logic              pend_last;
  // Set once the pending byte went through the append rule; a last byte whose
  // append caused a flush comes back to APPEND only for the final run.
  logic              byte_done;

  // Captured timestamp, shifted right one byte per TS cycle (LSB first).
  logic [TsW-1:0]    ts_shift;
  logic [TsCntW-1:0] ts_left;

  // Per-level frame contexts.
  logic [7:0]        run_buf [NumLevels][MaxRun];
  logic [CntW-1:0]   run_cnt [NumLevels];
  logic [NumLevels-1:0] in_frame;

  logic [7:0]        code_reg;
  logic [IdxW-1:0]   data_idx;

  // Control strobes from the next-state logic into the datapath.
  logic              accept_byte;
  logic              store_en;
  logic              flush_en;
  logic [7:0]        flush_code;
  logic              ts_step;
  logic              mark_done;
  logic              idx_inc;
  logic              cnt_clr;
  logic              frame_clr;

  logic              lvl_ok;
  logic              lvl_open;
  logic [CntW-1:0]   cur_cnt;
  logic [7:0]        app_byte;
  logic              rule_store;
  logic              rule_flush;
  logic [7:0]        rule_code;

  // Only the low TsW bits of the timer form the timestamp.
  logic              unused_timer_bits;
  assign unused_timer_bits = ^timer;

  assign lvl_ok  = int'(in_level) < NumLevels;
  assign cur_cnt = run_cnt[pend_level];

  always_comb begin
    lvl_open = 1'b0;
    for (int i = 0; i < NumLevels; i++) begin
      if (in_level == LevelW'(i)) lvl_open = in_frame[i];
    end
  end

  // Append rule for the byte currently being processed (timestamp or payload):
  // a zero closes the run with code count+1; a non-zero byte is stored and a
  // run reaching MaxRun bytes closes with code MaxRun+1 (no implied zero).
  always_comb begin
    app_byte   = (state == S_TS) ? ts_shift[7:0] : pend_data;
    rule_store = (app_byte != 8'h00);
    rule_flush = (app_byte == 8'h00) || (int'(cur_cnt) + 1 == MaxRun);
    rule_code  = (app_byte == 8'h00) ? 8'(cur_cnt) + 8'd1 : 8'(MaxRun + 1);
  end

  // NOTE: every signal written here gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    ret_d       = ret_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    out_last    = 1'b0;
    accept_byte = 1'b0;
    store_en    = 1'b0;
    flush_en    = 1'b0;
    flush_code  = 8'h00;
    ts_step     = 1'b0;
    mark_done   = 1'b0;
    idx_inc     = 1'b0;
    cnt_clr     = 1'b0;
    frame_clr   = 1'b0;

    case (state)
      S_IDLE: begin
        in_ready = !reset_i;
        if (in_valid && !reset_i && lvl_ok) begin
          accept_byte = 1'b1;
          state_d     = (!lvl_open && TsBytes > 0) ? S_TS : S_APPEND;
        end
      end

      S_TS: begin
        store_en = rule_store;
        ts_step  = 1'b1;
        if (rule_flush) begin
          flush_en   = 1'b1;
          flush_code = rule_code;
          ret_d      = (ts_left == TsCntW'(1)) ? S_APPEND : S_TS;
          state_d    = S_CODE;
        end else begin
          state_d    = (ts_left == TsCntW'(1)) ? S_APPEND : S_TS;
        end
      end

      S_APPEND: begin
        if (!byte_done) begin
          store_en  = rule_store;
          mark_done = 1'b1;
          if (rule_flush) begin
            flush_en   = 1'b1;
            flush_code = rule_code;
            ret_d      = pend_last ? S_APPEND : S_IDLE;
            state_d    = S_CODE;
          end else if (pend_last) begin
            // Byte is stored this cycle, so the final run holds count+1 bytes.
            flush_en   = 1'b1;
            flush_code = 8'(cur_cnt) + 8'd2;
            ret_d      = S_DELIM;
            state_d    = S_CODE;
          end else begin
            state_d    = S_IDLE;
          end
        end else begin
          flush_en   = 1'b1;
          flush_code = 8'(cur_cnt) + 8'd1;
          ret_d      = S_DELIM;
          state_d    = S_CODE;
        end
      end

      S_CODE: begin
        out_valid = 1'b1;
        out_data  = code_reg;
        if (out_ready) state_d = (cur_cnt == '0) ? ret_state : S_DATA;
      end

      S_DATA: begin
        out_valid = 1'b1;
        out_data  = run_buf[pend_level][data_idx];
        if (out_ready) begin
          if (int'(data_idx) + 1 == int'(cur_cnt)) begin
            cnt_clr = 1'b1;
            state_d = ret_state;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end

      S_DELIM: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        if (out_ready) begin
          frame_clr = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign out_level = out_valid ? pend_level : '0;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples the values from before this clock edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= S_IDLE;
      ret_state  <= S_IDLE;
      pend_level <= '0;
      pend_data  <= 8'h00;
      pend_last  <= 1'b0;
      byte_done  <= 1'b0;
      ts_shift   <= '0;
      ts_left    <= '0;
      in_frame   <= '0;
      code_reg   <= 8'h00;
      data_idx   <= '0;
      for (int i = 0; i < NumLevels; i++) run_cnt[i] <= '0;
    end else begin
      state     <= state_d;
      ret_state <= ret_d;

      if (accept_byte) begin
        pend_level <= in_level;
        pend_data  <= in_data;
        pend_last  <= in_last;
        byte_done  <= 1'b0;
        ts_shift   <= TsW'(timer);
        ts_left    <= TsCntW'(TsBytes);
        for (int i = 0; i < NumLevels; i++) begin
          if (in_level == LevelW'(i)) in_frame[i] <= 1'b1;
        end
      end

      if (mark_done) byte_done <= 1'b1;

      if (ts_step) begin
        ts_shift <= ts_shift >> 8;
        ts_left  <= ts_left - TsCntW'(1);
      end

      if (store_en) run_cnt[pend_level] <= cur_cnt + CntW'(1);
      if (cnt_clr)  run_cnt[pend_level] <= '0;

      if (flush_en) begin
        code_reg <= flush_code;
        data_idx <= '0;
      end else if (idx_inc) begin
        data_idx <= data_idx + IdxW'(1);
      end

      if (frame_clr) in_frame[pend_level] <= 1'b0;
    end
  end

  // NOTE: the run buffers are not reset; a cleared count makes stale contents
  // unreachable, and leaving them out of reset keeps them plain storage.
  always_ff @(posedge clk_i) begin
    if (store_en) run_buf[pend_level][IdxW'(cur_cnt)] <= app_byte;
  end

endmodule

// File: tb/tb_cobs_frame_encoder.sv
// -----------------------------------------------------------------------------
// tb_cobs_frame_encoder
//
// Two encoder instances share the input stimulus: one without timestamps and
// one with 4-byte timestamps; `sel` picks which one is driven and observed.
// A queue-based reference model turns each accepted byte into the COBS bytes
// it must eventually produce; a monitor pops and compares on every transfer.
// -----------------------------------------------------------------------------
module tb_cobs_frame_encoder;

  localparam int NL = 3;  // level 3 is out of range on the 2-bit level bus
  localparam int MR = 7;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] level;
    logic       last;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        in_valid, in_last, out_ready;
  logic [1:0]  in_level;
  logic [7:0]  in_data;
  logic [31:0] timer;
  logic        timer_run;

  logic       in_ready0, out_valid0, out_last0;
  logic [7:0] out_data0;
  logic [1:0] out_level0;
  logic       in_ready4, out_valid4, out_last4;
  logic [7:0] out_data4;
  logic [1:0] out_level4;

  logic       in_ready, out_valid, out_last;
  logic [7:0] out_data;
  logic [1:0] out_level;

  int n_checks = 0;
  int n_errors = 0;

  item_t      exp_q[$];
  logic [7:0] run_q[NL][$];
  bit         open_f[NL];
  int         ts_bytes;

  bit ready_random = 1'b0;
  bit ready_manual = 1'b0;
  bit hold37_arm   = 1'b0;
  int hold_left    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (timer_run) timer <= timer + 32'h0102_0305;

  cobs_frame_encoder #(.NumLevels(NL), .MaxRun(MR), .TsBytes(0), .TimerWidth(32)) dut0 (
    .clk_i(clk), .reset_i(rst),
    .in_valid(in_valid && !sel), .in_ready(in_ready0), .in_level(in_level),
    .in_data(in_data), .in_last(in_last), .timer(timer),
    .out_valid(out_valid0), .out_ready(out_ready && !sel), .out_data(out_data0),
    .out_level(out_level0), .out_last(out_last0)
  );

  cobs_frame_encoder #(.NumLevels(NL), .MaxRun(MR), .TsBytes(4), .TimerWidth(32)) dut4 (
    .clk_i(clk), .reset_i(rst),
    .in_valid(in_valid && sel), .in_ready(in_ready4), .in_level(in_level),
    .in_data(in_data), .in_last(in_last), .timer(timer),
    .out_valid(out_valid4), .out_ready(out_ready && sel), .out_data(out_data4),
    .out_level(out_level4), .out_last(out_last4)
  );

  assign in_ready  = sel ? in_ready4  : in_ready0;
  assign out_valid = sel ? out_valid4 : out_valid0;
  assign out_data  = sel ? out_data4  : out_data0;
  assign out_level = sel ? out_level4 : out_level0;
  assign out_last  = sel ? out_last4  : out_last0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic item_t mk(input int d, input int l, input bit last);
    item_t it;
    it.data  = 8'(d);
    it.level = 2'(l);
    it.last  = last;
    return it;
  endfunction

  function automatic void emit_run(input int l, input int code);
    exp_q.push_back(mk(code, l, 1'b0));
    for (int i = 0; i < run_q[l].size(); i++) exp_q.push_back(mk(run_q[l][i], l, 1'b0));
    run_q[l].delete();
  endfunction

  function automatic void model_byte(input int l, input logic [7:0] b);
    if (b == 8'h00) begin
      emit_run(l, run_q[l].size() + 1);
    end else begin
      run_q[l].push_back(b);
      if (run_q[l].size() == MR) emit_run(l, MR + 1);
    end
  endfunction

  function automatic void model_accept(input int l, input logic [7:0] d, input bit last,
                                       input logic [31:0] ts);
    if (l >= NL) return;
    if (!open_f[l]) begin
      open_f[l] = 1'b1;
      for (int k = 0; k < ts_bytes; k++) model_byte(l, 8'(ts >> (8 * k)));
    end
    model_byte(l, d);
    if (last) begin
      emit_run(l, run_q[l].size() + 1);
      exp_q.push_back(mk(0, l, 1'b1));
      open_f[l] = 1'b0;
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    for (int l = 0; l < NL; l++) begin
      run_q[l].delete();
      open_f[l] = 1'b0;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input int l, input logic [7:0] d, input bit last);
    int waited = 0;
    in_valid = 1'b1;
    in_level = 2'(l);
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 400) begin
        fail_bound("in_ready_wait");
        in_valid = 1'b0;
        return;
      end
    end
    model_accept(l, d, last, timer);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_pending", exp_q.size(), 0);
    check("idle_out_valid", out_valid, 0);
  endtask

  task automatic scenario1();
    send(1, 8'h13, 1'b0);
    send(1, 8'h00, 1'b0);
    send(1, 8'h37, 1'b0);
    send(1, 8'hDE, 1'b1);
  endtask

  task automatic random_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      d = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
      send(int'($urandom_range(3)), d, $urandom_range(4) == 0);
    end
  endtask

  // out_ready: random or always-high, with a 3-cycle stall on byte 0x37.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!ready_manual) begin
        if (hold37_arm && out_valid && out_data == 8'h37) begin
          hold37_arm = 1'b0;
          hold_left  = 3;
        end
        if (hold_left > 0) begin
          out_ready = 1'b0;
          hold_left--;
        end else begin
          out_ready = ready_random ? ($urandom_range(3) != 0) : 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit         have_prev = 1'b0;
    logic [7:0] prev_data;
    logic [1:0] prev_level;
    logic       prev_last;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_prev = 1'b0;
        continue;
      end
      if (have_prev) begin
        check("hold_data", out_data, prev_data);
        check("hold_level", out_level, prev_level);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid) check("in_ready_while_output", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got data %0h level %0d last %0d, expected none",
                   out_data, out_level, out_last);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_level", out_level, e.level);
          check("out_last", out_last, e.last);
        end
      end
      have_prev  = out_valid && !out_ready;
      prev_data  = out_data;
      prev_level = out_level;
      prev_last  = out_last;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int w;
    sel       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_level  = 2'd0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    timer     = 32'h0;
    timer_run = 1'b1;
    ts_bytes  = 0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_last", out_last, 0);
    check("reset_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", in_ready, 1);

    // Scenario: zero splits the run, final run closes the frame.
    scenario1();
    drain();

    // Full run of MaxRun bytes, then a one-byte final run.
    for (int i = 1; i <= 8; i++) send(0, 8'(i), i == 8);
    drain();

    // Preemption: level 2 frame completes while level 1 is open.
    send(1, 8'h11, 1'b0);
    send(2, 8'h22, 1'b1);
    send(1, 8'h33, 1'b1);
    drain();

    // Backpressure stall on 0x37.
    hold37_arm = 1'b1;
    scenario1();
    drain();
    check("stall_on_37_seen", hold37_arm, 0);

    // Reset during DATA of an open level 1 run.
    ready_manual = 1'b1;
    out_ready    = 1'b0;
    for (int i = 1; i <= 7; i++) send(1, 8'(i), 1'b0);
    w = 0;
    while (!(out_valid && out_data == 8'h08) && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 50) fail_bound("code_wait");
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("data_before_reset", out_data, 8'h01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_level", out_level, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    model_clear();
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_in_ready", in_ready, 1);
    ready_manual = 1'b0;
    send(1, 8'h05, 1'b1);
    drain();

    // Randomized traffic, including the out-of-range level.
    ready_random = 1'b1;
    random_bytes(150);
    drain();

    // Timestamped instance.
    ready_random = 1'b0;
    model_clear();
    sel      = 1'b1;
    ts_bytes = 4;
    @(posedge clk);
    #1;
    timer_run = 1'b0;
    timer     = 32'h0045_0089;
    send(0, 8'hAA, 1'b1);
    drain();
    timer_run = 1'b1;

    ready_random = 1'b1;
    random_bytes(150);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
